// File: rtl/or1200_vlx_pack.sv
// Variable-length code packer: accumulates MSB-first codes into a 24-bit
// window and hands complete bytes to the store unit, stuffing 0x00 after 0xFF.
module or1200_vlx_pack (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [4:0]  len_i,
  input  logic [15:0] bits_i,
  input  logic        flush_i,
  input  logic        ack_i,
  output logic        store_byte_o,
  output logic [31:0] dat_o,
  output logic        ready_o,
  output logic [4:0]  bit_cnt_o
);

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned CODE_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(CODE_W);
  localparam logic [CNT_W-1:0] BYTE_LEN = CNT_W'(BYTE_W);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] CHECK      = 3'd1;
  localparam logic [2:0] EMIT       = 3'd2;
  localparam logic [2:0] WAIT       = 3'd3;
  localparam logic [2:0] STUFF_EMIT = 3'd4;
  localparam logic [2:0] STUFF_WAIT = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              ready_q, ready_d;

  logic [CNT_W-1:0]  len_eff;
  logic [CODE_W-1:0] code_mask;
  logic [CODE_W-1:0] code_bits;
  logic [CNT_W-1:0]  pad_len;
  logic [BYTE_W-1:0] pad_ones;
  logic [BYTE_W-1:0] top_byte;

  // Code conditioning: clamp oversize lengths, drop bits above the length.
  always_comb begin
    len_eff   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    code_mask = CODE_W'((17'd1 << len_eff) - 17'd1);
    code_bits = bits_i & code_mask;
    pad_len   = BYTE_LEN - cnt_q;
    pad_ones  = BYTE_W'((9'd1 << pad_len) - 9'd1);
    top_byte  = BYTE_W'(acc_q >> (cnt_q - BYTE_LEN));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    store_d = 1'b0;
    byte_d  = byte_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          acc_d   = (acc_q << len_eff) | ACC_W'(code_bits);
          cnt_d   = cnt_q + len_eff;
          state_d = CHECK;
        end else if (flush_i && (cnt_q[2:0] != 3'd0)) begin
          acc_d   = (acc_q << pad_len) | ACC_W'(pad_ones);
          cnt_d   = BYTE_LEN;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cnt_q >= BYTE_LEN) begin
          store_d = 1'b1;
          byte_d  = top_byte;
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: state_d = WAIT;
      WAIT: begin
        if (ack_i) begin
          cnt_d = cnt_q - BYTE_LEN;
          if (byte_q == 8'hFF) begin
            store_d = 1'b1;
            byte_d  = '0;
            state_d = STUFF_EMIT;
          end else begin
            state_d = CHECK;
          end
        end
      end
      STUFF_EMIT: state_d = STUFF_WAIT;
      STUFF_WAIT: begin
        if (ack_i) state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      store_q <= 1'b0;
      byte_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      byte_q  <= byte_d;
      ready_q <= ready_d;
    end
  end

  assign store_byte_o = store_q;
  assign dat_o        = {24'd0, byte_q};
  assign ready_o      = ready_q;
  assign bit_cnt_o    = cnt_q;

endmodule

// File: tb/tb_or1200_vlx_pack.sv
// Bench for or1200_vlx_pack: directed scenarios plus random codes checked
// against a bit-queue model of the packed stream.
module tb_or1200_vlx_pack;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [4:0]  len_i;
  logic [15:0] bits_i;
  logic        flush_i;
  logic        ack_i;
  logic        store_byte_o;
  logic [31:0] dat_o;
  logic        ready_o;
  logic [4:0]  bit_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  bit         model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         hi_bad;

  always #5 clk_i = ~clk_i;

  or1200_vlx_pack dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .len_i(len_i),
    .bits_i(bits_i), .flush_i(flush_i), .ack_i(ack_i),
    .store_byte_o(store_byte_o), .dat_o(dat_o), .ready_o(ready_o),
    .bit_cnt_o(bit_cnt_o)
  );

  task automatic model_push(input logic [4:0] len, input logic [15:0] bits);
    int l;
    l = (int'(len) > 16) ? 16 : int'(len);
    for (int i = l - 1; i >= 0; i--) model_q.push_back(bits[i]);
  endtask

  task automatic model_flush();
    while ((model_q.size() % 8) != 0) model_q.push_back(1'b1);
  endtask

  task automatic model_drain();
    logic [7:0] b;
    exp_q.delete();
    while (model_q.size() >= 8) begin
      b = '0;
      for (int k = 0; k < 8; k++) b = {b[6:0], model_q.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  // Presents one input at a negedge and collects every byte pulse until idle.
  task automatic run_code(input logic v, input logic f, input logic [4:0] len,
                          input logic [15:0] bits, input int ack_dly,
                          output int first_lat, output bit timeout);
    int guard;
    int cyc;
    int cd;
    got_q.delete();
    hi_bad    = 1'b0;
    first_lat = -1;
    timeout   = 1'b0;
    guard     = 0;
    while (!ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    if (!ready_o) begin
      timeout = 1'b1;
      return;
    end
    valid_i = v; flush_i = f; len_i = len; bits_i = bits;
    @(posedge clk_i);
    cyc = 0;
    cd  = 0;
    while (cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      valid_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0;
      if (store_byte_o) begin
        got_q.push_back(dat_o[7:0]);
        if (dat_o[31:8] != 24'd0) hi_bad = 1'b1;
        if (first_lat < 0) first_lat = cyc;
        cd = ack_dly;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) ack_i = 1'b1;
      end
      if (ready_o && cd == 0 && !ack_i) break;
    end
    if (cyc >= 300) timeout = 1'b1;
    ack_i = 1'b0;
  endtask

  task automatic test_reset();
    int lat; bit to;
    #12;
    n_cmp++; if (store_byte_o !== 1'b0) begin n_bad++; $display("FAIL rst_store: got %0b want 0", store_byte_o); end
    n_cmp++; if (dat_o !== 32'd0) begin n_bad++; $display("FAIL rst_dat: got %0h want 0", dat_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", ready_o); end
    n_cmp++; if (bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", bit_cnt_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    run_code(1'b1, 1'b0, 5'd4, 16'h0009, 1, lat, to);
    n_cmp++; if (bit_cnt_o !== 5'd4) begin n_bad++; $display("FAIL pre_async_cnt: got %0d want 4", bit_cnt_o); end
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    n_cmp++; if (bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL async_cnt: got %0d want 0", bit_cnt_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL async_ready: got %0b want 1", ready_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    model_q.delete();
  endtask

  task automatic test_single_byte();
    int lat; bit to;
    run_code(1'b1, 1'b0, 5'd8, 16'h00A5, 3, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got %0b want 0", to); end
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_byte: got %0h want a5", got_q[0]); end
    end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", lat); end
    n_cmp++; if (hi_bad !== 1'b0) begin n_bad++; $display("FAIL single_dat_hi: got %0b want 0", hi_bad); end
    n_cmp++; if (ready_o !== 1'b1 || bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL single_end: ready %0b cnt %0d want 1/0", ready_o, bit_cnt_o); end
  endtask

  task automatic test_stuff();
    int lat; bit to;
    logic [7:0] want [3];
    want = '{8'hFF, 8'h00, 8'h12};
    run_code(1'b1, 1'b0, 5'd16, 16'hFF12, 2, lat, to);
    n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL stuff_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL stuff_byte%0d: got %0h want %0h", i, got_q[i], want[i]); end
    end
    n_cmp++; if (bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL stuff_cnt: got %0d want 0", bit_cnt_o); end
  endtask

  task automatic test_two_codes();
    int lat; bit to;
    run_code(1'b1, 1'b0, 5'd4, 16'h000A, 1, lat, to);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL two_first_count: got %0d want 0", got_q.size()); end
    n_cmp++; if (bit_cnt_o !== 5'd4) begin n_bad++; $display("FAIL two_first_cnt: got %0d want 4", bit_cnt_o); end
    run_code(1'b1, 1'b0, 5'd12, 16'h0BCD, 2, lat, to);
    n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL two_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_cmp++; if (got_q[0] !== 8'hAB || got_q[1] !== 8'hCD) begin n_bad++; $display("FAIL two_bytes: got %0h %0h want ab cd", got_q[0], got_q[1]); end
    end
    n_cmp++; if (bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL two_cnt: got %0d want 0", bit_cnt_o); end
  endtask

  task automatic test_flush();
    int lat; bit to;
    run_code(1'b1, 1'b0, 5'd3, 16'h0005, 1, lat, to);
    n_cmp++; if (bit_cnt_o !== 5'd3 || got_q.size() != 0) begin n_bad++; $display("FAIL flush_pre: cnt %0d bytes %0d want 3/0", bit_cnt_o, got_q.size()); end
    run_code(1'b0, 1'b1, 5'd0, 16'h0000, 1, lat, to);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL flush_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== 8'hBF) begin n_bad++; $display("FAIL flush_byte: got %0h want bf", got_q[0]); end
    end
    n_cmp++; if (bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL flush_cnt: got %0d want 0", bit_cnt_o); end
    run_code(1'b0, 1'b1, 5'd0, 16'h0000, 1, lat, to);
    n_cmp++; if (got_q.size() != 0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_empty: bytes %0d ready %0b want 0/1", got_q.size(), ready_o); end
  endtask

  task automatic test_reset_in_wait();
    int lat; bit to; int guard;
    valid_i = 1'b1; len_i = 5'd8; bits_i = 16'h003C;
    @(posedge clk_i);
    guard = 0;
    do begin
      @(negedge clk_i);
      valid_i = 1'b0;
      guard++;
    end while (!store_byte_o && guard < 20);
    n_cmp++; if (store_byte_o !== 1'b1) begin n_bad++; $display("FAIL rw_pulse: got %0b want 1", store_byte_o); end
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    n_cmp++; if (store_byte_o !== 1'b0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL rw_reset: store %0b ready %0b want 0/1", store_byte_o, ready_o); end
    n_cmp++; if (bit_cnt_o !== 5'd0 || dat_o !== 32'd0) begin n_bad++; $display("FAIL rw_state: cnt %0d dat %0h want 0/0", bit_cnt_o, dat_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    n_cmp++; if (store_byte_o !== 1'b0 || ready_o !== 1'b1 || bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL rw_stray_ack: store %0b ready %0b cnt %0d want 0/1/0", store_byte_o, ready_o, bit_cnt_o); end
    run_code(1'b1, 1'b0, 5'd8, 16'h005A, 1, lat, to);
    n_cmp++; if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 8'h5A)) begin n_bad++; $display("FAIL rw_recover: bytes %0d first %0h want 1 x 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00); end
    model_q.delete();
  endtask

  task automatic test_random();
    int lat; bit to; int r; logic v, f; logic [4:0] len; logic [15:0] bits;
    for (int it = 0; it < 80; it++) begin
      r    = int'($urandom_range(0, 9));
      v    = (r < 7);
      f    = (r >= 5);
      len  = 5'($urandom_range(0, 31));
      bits = 16'($urandom);
      if (v) model_push(len, bits);
      else if (f) model_flush();
      model_drain();
      run_code(v, f, len, bits, int'($urandom_range(1, 4)), lat, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_timeout: got %0b want 0", it, to); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd%0d_byte%0d: got %0h want %0h", it, i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (int'(bit_cnt_o) != model_q.size()) begin n_bad++; $display("FAIL rnd%0d_cnt: got %0d want %0d", it, bit_cnt_o, model_q.size()); end
      n_cmp++; if (hi_bad !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_dat_hi: got %0b want 0", it, hi_bad); end
    end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0;
    len_i = '0; bits_i = '0;
    test_reset();
    test_single_byte();
    test_stuff();
    test_two_codes();
    test_flush();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
